// File: rtl/hc595_chain_driver_if.sv
// Parallel-word handshake between a data source and hc595_chain_driver.
interface hc595_chain_driver_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             READY;
    logic             DONE;

    modport master (output DATA, output VALID, input READY, input DONE);
    modport slave  (input DATA, input VALID, output READY, output DONE);
endinterface

// File: rtl/hc595_chain_driver.sv
// Shifts one parallel word MSB first into a 74HC595 chain, then pulses RCLK to latch it.
// Optional HC595_READBACK_EN captures the chain's previous contents from QH_IN during the shift.
module hc595_chain_driver #(
    parameter int WIDTH = 16,
    parameter int DIV   = 2
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    hc595_chain_driver_if.slave  bus,
    output logic                 SER,
    output logic                 SRCLK,
    output logic                 RCLK,
    output logic                 SRCLRb,
    output logic                 OEb
`ifdef HC595_READBACK_EN
    ,
    input  logic                 QH_IN,
    output logic [WIDTH-1:0]     RDBK,
    output logic                 RDBK_VALID
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV + 1) : 1;

    generate
        if (DIV < 1 || WIDTH < 1) begin : g_bad_param
            $error("hc595_chain_driver: WIDTH and DIV must both be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {INIT, IDLE, SETUP, HIGH, LATCH} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    div_q, div_d;
    logic             ser_q, ser_d;
    logic             srclk_q, srclk_d;
    logic             rclk_q, rclk_d;
    logic             srclrb_q, srclrb_d;
    logic             oeb_q, oeb_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             div_last;
`ifdef HC595_READBACK_EN
    logic [WIDTH-1:0] rdbk_q, rdbk_d;
    logic             rdbk_valid_q, rdbk_valid_d;
`endif

    assign div_last = (div_q == DW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        div_d    = div_q + DW'(1);
        ser_d    = ser_q;
        srclk_d  = srclk_q;
        rclk_d   = rclk_q;
        srclrb_d = srclrb_q;
        oeb_d    = oeb_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
`ifdef HC595_READBACK_EN
        rdbk_d       = rdbk_q;
        rdbk_valid_d = 1'b0;
`endif
        case (state_q)
            INIT: begin
                srclrb_d = 1'b1;
                ready_d  = 1'b1;
                div_d    = '0;
                state_d  = IDLE;
            end
            IDLE: begin
                div_d = '0;
                if (bus.VALID && ready_q) begin
                    sr_d    = bus.DATA;
                    cnt_d   = CW'(WIDTH);
                    ready_d = 1'b0;
                    ser_d   = bus.DATA[WIDTH-1];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    srclk_d = 1'b1;
                    state_d = HIGH;
`ifdef HC595_READBACK_EN
                    // QH_IN still shows the last stage before this rising edge shifts it.
                    rdbk_d = (rdbk_q << 1) | WIDTH'(QH_IN);
`endif
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_d   = '0;
                    srclk_d = 1'b0;
                    sr_d    = sr_q << 1;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rclk_d  = 1'b1;
                        state_d = LATCH;
                    end else begin
                        ser_d   = sr_d[WIDTH-1];
                        state_d = SETUP;
                    end
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    rclk_d  = 1'b0;
                    oeb_d   = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
`ifdef HC595_READBACK_EN
                    rdbk_valid_d = 1'b1;
`endif
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q  <= INIT;
            sr_q     <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            ser_q    <= 1'b0;
            srclk_q  <= 1'b0;
            rclk_q   <= 1'b0;
            srclrb_q <= 1'b0;
            oeb_q    <= 1'b1;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            ser_q    <= ser_d;
            srclk_q  <= srclk_d;
            rclk_q   <= rclk_d;
            srclrb_q <= srclrb_d;
            oeb_q    <= oeb_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

`ifdef HC595_READBACK_EN
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rdbk_q       <= '0;
            rdbk_valid_q <= 1'b0;
        end else begin
            rdbk_q       <= rdbk_d;
            rdbk_valid_q <= rdbk_valid_d;
        end
    end

    assign RDBK       = rdbk_q;
    assign RDBK_VALID = rdbk_valid_q;
`endif

    assign SER       = ser_q;
    assign SRCLK     = srclk_q;
    assign RCLK      = rclk_q;
    assign SRCLRb    = srclrb_q;
    assign OEb       = oeb_q;
    assign bus.READY = ready_q;
    assign bus.DONE  = done_q;
endmodule

// File: tb/tb_hc595_chain_driver.sv
// Scoreboard bench: stimulus pushes expected words, a monitor checks them at each DONE against a 74HC595 chain model.
`timescale 1ns/1ps
module tb_hc595_chain_driver;
    typedef struct {
        logic [15:0] word;
        logic [15:0] rdbk;
        int          acc;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    hc595_chain_driver_if #(.WIDTH(16)) bus ();
    hc595_chain_driver_if #(.WIDTH(8))  bus2 ();
    logic SER, SRCLK, RCLK, SRCLRb, OEb;
    logic SER2, SRCLK2, RCLK2, SRCLRb2, OEb2;
`ifdef HC595_READBACK_EN
    logic        QH_IN;
    logic [15:0] RDBK;
    logic        RDBK_VALID;
    logic        QH_IN2;
    logic [7:0]  RDBK2;
    logic        RDBK_VALID2;
`endif

    hc595_chain_driver #(.WIDTH(16), .DIV(2)) dut (
        .CLK(CLK), .RSTb(RSTb), .bus(bus),
        .SER(SER), .SRCLK(SRCLK), .RCLK(RCLK), .SRCLRb(SRCLRb), .OEb(OEb)
`ifdef HC595_READBACK_EN
        , .QH_IN(QH_IN), .RDBK(RDBK), .RDBK_VALID(RDBK_VALID)
`endif
    );

    hc595_chain_driver #(.WIDTH(8), .DIV(1)) dut2 (
        .CLK(CLK), .RSTb(RSTb), .bus(bus2),
        .SER(SER2), .SRCLK(SRCLK2), .RCLK(RCLK2), .SRCLRb(SRCLRb2), .OEb(OEb2)
`ifdef HC595_READBACK_EN
        , .QH_IN(QH_IN2), .RDBK(RDBK2), .RDBK_VALID(RDBK_VALID2)
`endif
    );

    // 74HC595 chain model: shift register cleared by SRCLRb, storage latched on RCLK
    logic [15:0] ch_sr = 16'h0;
    logic [15:0] ch_lat = 16'h0;
    logic [7:0]  sr2 = 8'h0;
    int          ones2 = 0;
    int          n_srclk = 0;
    int          n_rclk = 0;
`ifdef HC595_READBACK_EN
    assign QH_IN  = ch_sr[15];
    assign QH_IN2 = 1'b0;
`endif

    initial forever begin
        @(posedge SRCLK or negedge SRCLRb);
        if (!SRCLRb) ch_sr = 16'h0;
        else begin
            ch_sr = {ch_sr[14:0], SER};
            n_srclk++;
        end
    end
    initial forever begin
        @(posedge RCLK);
        ch_lat = ch_sr;
        n_rclk++;
    end
    initial forever begin
        @(posedge SRCLK2);
        sr2 = {sr2[6:0], SER2};
        ones2 += int'(SER2);
    end
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    exp_t exp_q[$];
    int   rd_idx = 0;

    // Monitor: pops one expectation per DONE pulse
    initial begin
        int sbase = 0;
        int rbase = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RSTb) begin
                rd_idx = exp_q.size();
                sbase  = n_srclk;
                rbase  = n_rclk;
            end else if (bus.DONE) begin
                if (rd_idx >= exp_q.size()) begin
                    chk("unexpected_done", 32'(bus.DONE), 32'd0);
                end else begin
                    e = exp_q[rd_idx];
                    rd_idx++;
                    chk("chain_word", 32'(ch_lat), 32'(e.word));
                    chk("done_latency", 32'(cyc - e.acc), 32'd66);
                    chk("srclk_rises", 32'(n_srclk - sbase), 32'd16);
                    chk("rclk_rises", 32'(n_rclk - rbase), 32'd1);
                    chk("oeb_at_done", 32'(OEb), 32'd0);
                    chk("ready_at_done", 32'(bus.READY), 32'd1);
`ifdef HC595_READBACK_EN
                    chk("rdbk", 32'(RDBK), 32'(e.rdbk));
                    chk("rdbk_valid", 32'(RDBK_VALID), 32'd1);
`endif
                    sbase = n_srclk;
                    rbase = n_rclk;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge before the accepting edge.
    task automatic send(input logic [15:0] w, input logic [15:0] rb);
        int t = 0;
        exp_t e;
        bus.DATA  = w;
        bus.VALID = 1'b1;
        while (!bus.READY && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.READY) chk("send_timeout", 32'(bus.READY), 32'd1);
        else begin
            e.word = w;
            e.rdbk = rb;
            e.acc  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.DONE && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.DONE) chk("done_timeout", 32'(bus.DONE), 32'd1);
    endtask

    initial begin
        int s0;
        int t;
        int n;
        bus.DATA   = 16'h0;
        bus.VALID  = 1'b0;
        bus2.DATA  = 8'h0;
        bus2.VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_ser", 32'(SER), 32'd0);
        chk("rst_srclk", 32'(SRCLK), 32'd0);
        chk("rst_rclk", 32'(RCLK), 32'd0);
        chk("rst_srclrb", 32'(SRCLRb), 32'd0);
        chk("rst_oeb", 32'(OEb), 32'd1);
        chk("rst_ready", 32'(bus.READY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        RSTb = 1'b1;
        @(negedge CLK);
        chk("init_ready", 32'(bus.READY), 32'd1);
        chk("init_srclrb", 32'(SRCLRb), 32'd1);
        chk("init_oeb", 32'(OEb), 32'd1);

        // single word
        send(16'hA5C3, 16'h0000);
        @(negedge CLK);
        bus.VALID = 1'b0;
        chk("accept_ready_drop", 32'(bus.READY), 32'd0);
        wait_done();

        // back-to-back with VALID held; DATA changes mid-flight are ignored
        send(16'hFFFF, 16'hA5C3);
        @(negedge CLK);
        bus.DATA = 16'h0001;
        wait_done();
        send(16'h0001, 16'hFFFF);
        @(negedge CLK);
        chk("b2b_accept", 32'(bus.READY), 32'd0);
        bus.DATA = 16'h0000;
        wait_done();
        bus.VALID = 1'b0;
        repeat (20) @(negedge CLK);

        // reset after the 7th SRCLK rise
        s0 = n_srclk;
        send(16'h5A5A, 16'h0001);
        @(negedge CLK);
        bus.VALID = 1'b0;
        t = 0;
        while (n_srclk < s0 + 7 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk("pre_rst_srclk_high", 32'(SRCLK), 32'd1);
        #2 RSTb = 1'b0;
        #1;
        chk("mid_rst_ser", 32'(SER), 32'd0);
        chk("mid_rst_srclk", 32'(SRCLK), 32'd0);
        chk("mid_rst_rclk", 32'(RCLK), 32'd0);
        chk("mid_rst_srclrb", 32'(SRCLRb), 32'd0);
        chk("mid_rst_oeb", 32'(OEb), 32'd1);
        chk("mid_rst_ready", 32'(bus.READY), 32'd0);
        chk("mid_rst_chain_clr", 32'(ch_sr), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        @(negedge CLK);
        chk("rel_ready", 32'(bus.READY), 32'd1);
        repeat (100) @(negedge CLK);

        // readback sequence: chain cleared by reset, then holds 1234
        send(16'h1234, 16'h0000);
        @(negedge CLK);
        bus.DATA = 16'hBEEF;
        wait_done();
        send(16'hBEEF, 16'h1234);
        @(negedge CLK);
        bus.VALID = 1'b0;
        wait_done();
        repeat (5) @(negedge CLK);
        chk("all_done_seen", 32'(rd_idx), 32'(exp_q.size()));

        // WIDTH=8, DIV=1
        chk("w8_ready", 32'(bus2.READY), 32'd1);
        bus2.DATA  = 8'h80;
        bus2.VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) bus2.VALID = 1'b0;
        end while (!bus2.DONE && n < 100);
        chk("w8_latency", 32'(n - 1), 32'd17);
        chk("w8_chain", 32'(sr2), 32'h80);
        chk("w8_ser_ones", 32'(ones2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
